// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in, parallel-out collector.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  // The bit counter must be able to hold OUTPUT_WIDTH-1.
  function automatic int sipo_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; presents the word including the bit sampled this cycle.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_sample,
  input  logic         i_serial_in,
  output logic [W-1:0] o_word,
  output logic         o_word_done
);

  localparam int            CW   = sipo_cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  r_shreg;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_base;
  logic [W-1:0]  w_next;

  // A frame start discards the partial word before the new bit goes in.
  assign w_base = i_clear ? '0 : r_shreg;

  if (MSB_FIRST) begin : g_msb
    assign w_next = (w_base << 1) | W'(i_serial_in);
  end else begin : g_lsb
    assign w_next = (w_base >> 1) | {i_serial_in, {(W-1){1'b0}}};
  end

  assign o_word      = w_next;
  assign o_word_done = i_sample && !i_clear && (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shreg <= i_sample ? w_next : '0;
      r_cnt   <= i_sample ? CW'(1) : '0;
    end else if (i_sample) begin
      r_shreg <= w_next;
      r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_collector.sv
// SIPO receiver: frame FSM, one-entry holding register with valid/ready and overflow pulse.
// state | meaning
// IDLE  | waiting for start, serial input ignored
// SHIFT | sampling serial_in on each shift_en cycle
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 8,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit CONTINUOUS   = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_shift_en,
  input  logic                    i_serial_in,
  output logic [OUTPUT_WIDTH-1:0] o_out_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_overflow,
  output logic                    o_busy
);

  sipo_state_t             r_state;
  logic                    r_busy;
  logic [OUTPUT_WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_ovf;

  logic                    w_sample;
  logic                    w_done;
  logic [OUTPUT_WIDTH-1:0] w_word;

  // The start cycle itself may carry the first bit of the new frame.
  assign w_sample = i_shift_en && (i_start || (r_state == SHIFT));

  sipo_shift_core #(
    .W         (OUTPUT_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_start),
    .i_sample    (w_sample),
    .i_serial_in (i_serial_in),
    .o_word      (w_word),
    .o_word_done (w_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (w_done) begin
        if (!r_valid || i_out_ready) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
      end

      if (i_start) begin
        r_state <= SHIFT;
        r_busy  <= 1'b1;
      end else if (w_done && !CONTINUOUS) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_overflow  = r_ovf;
  assign o_busy      = r_busy;

endmodule
